y3012_deserializer: RTL and testbench
=====================================

# y3012_deserializer

Receives the YM2151 serial DAC stream (SO, SH1, SH2) and converts it into signed 16-bit linear stereo samples, replacing the external YM3012 DAC. The block sits directly downstream of the y2151 synth core and upstream of the audio output path, for example a PWM or I2S stage, which takes samples over a valid/ready handshake. Each channel word is 10-bit mantissa plus 3-bit exponent floating point, delivered LSB first, and is decoded on the falling edge of that channel's sample-hold strobe.

## Interface
- No parameters.
- phiM  in  1  master clock, same clock as y2151; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- phi1  in  1  serial bit clock from the synth, synchronous to phiM; SO is sampled on its rising edge.
- SO  in  1  serial data, LSB first.
- SH1  in  1  channel 1 (left) sample-hold; falling edge ends the left word.
- SH2  in  1  channel 2 (right) sample-hold; falling edge ends the right word.
- left  out  16  signed left sample.
- right  out  16  signed right sample.
- out_valid  out  1  left/right pair is held and not yet consumed.
- out_ready  in  1  consumer accepts the pair when high together with out_valid.
- overrun  out  1  one-cycle pulse: an unconsumed pair was overwritten.
- frame_err  out  1  one-cycle pulse: a word or pair was discarded.

## Operation
- Edge detect:
  - phi1_q, sh1_q and sh2_q are registered copies of the inputs.
  - rise = phi1 & ~phi1_q.
  - fallN = shN_q & ~shN.
- Shifting: on rise, shreg <= {SO, shreg[15:1]} and bitcnt increments. bitcnt saturates at 16.
- Word layout after 16 shifts:
  - shreg[2:0] are dummy bits and are ignored.
  - M = shreg[12:3] is the mantissa, offset binary; its signed value is M - 512.
  - E = shreg[15:13] is the exponent.
- Decode:
  - E = 0 gives 0.
  - Otherwise the result is sign-extended (M - 512) shifted left by (E - 1).
  - The range is -32768 to +32704. No saturation is needed.
- On fall1:
  - If bitcnt = 16, decode into left_hold and set have_left.
  - Otherwise discard the word and pulse frame_err.
  - Either way, reset bitcnt.
- On fall2:
  - If bitcnt = 16 and have_left, decode into right, load left <= left_hold, set out_valid and clear have_left.
  - Otherwise discard and pulse frame_err.
  - Either way, reset bitcnt.
- Repeated fall1 without an intervening fall2 overwrites left_hold. This is not an error.
- Handshake:
  - out_valid & out_ready clears out_valid.
  - If a new pair loads while out_valid is high and out_ready is low, the new pair overwrites the old one, out_valid stays high and overrun pulses.
  - If a new pair loads while out_ready is high, the old pair counts as consumed, the new pair loads, out_valid stays high and there is no overrun.
- Simultaneous fall1 and fall2: fall1 is processed first, using the same shreg. The pair then completes with left = right = that word.
- Simultaneous fallN and rise: the decode uses shreg before the shift. The new bit becomes bit 1 of the next word, so bitcnt <= 1.
- Reset, including reset mid-word or mid-pair, clears:
  - shreg, bitcnt and have_left;
  - left_hold, left and right (set to 0);
  - out_valid, overrun and frame_err (set to 0);
  - the edge registers, which are reset to 1 so that no spurious fall is seen on release.

## Timing
- Only rising edges of phi1 count. SO must be stable on the phiM edge at which phi1 is first sampled high.
- Latency: left, right and out_valid update on the same phiM edge at which SH2 is first sampled low, i.e. the fall2 cycle.
- overrun and frame_err are high for exactly one cycle, aligned with the offending edge.
- left and right are stable while out_valid is high and change only on a new pair load.
- The block expects at least 16 phi1 rises between consecutive SH falls. Extra rises beyond 16 keep shifting, so the last 16 bits win.

## Test plan
- Word 0x7800 (M = 0x300, E = 3) on left, word 0xE800 (M = 0x100, E = 7) on right, then SH1 and SH2 falls: out_valid = 1, left = 0x0400, right = 0xC000.
- Extremes on left/right:
  - M = 0x3FF, E = 7 gives 0x7FC0; M = 0x000, E = 7 gives 0x8000.
  - Any M with E = 0 gives 0x0000.
- SH1 falls after only 10 phi1 rises: frame_err pulses, the following SH2 with a full word also pulses frame_err, and out_valid stays 0.
- Two pairs with out_ready held low: the second load pulses overrun and out_valid holds the second pair. Repeat with out_ready high on the load cycle: no overrun.
- Reset asserted after 8 bits of the left word: all outputs go to 0. A full pair sent after release decodes correctly.
- SH fall and phi1 rise in the same cycle: the decoded word excludes the new bit, and the next word needs only 15 further rises.

Source files
------------

// File: rtl/y3012_deserializer.sv
// YM3012 replacement: deserializes the YM2151 SO/SH1/SH2 DAC stream into
// signed 16-bit linear stereo samples behind a valid/ready handshake.
module y3012_deserializer (
    input  logic        phiM,
    input  logic        reset,
    input  logic        phi1,
    input  logic        SO,
    input  logic        SH1,
    input  logic        SH2,
    output logic [15:0] left,
    output logic [15:0] right,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overrun,
    output logic        frame_err
);

    logic        phi1_q, sh1_q, sh2_q;
    logic [15:0] shreg_q, shreg_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic        have_left_q, have_left_d;
    logic signed [15:0] left_hold_q, left_hold_d;
    logic signed [15:0] left_q, left_d;
    logic signed [15:0] right_q, right_d;
    logic        out_valid_q, out_valid_d;
    logic        overrun_q, overrun_d;
    logic        frame_err_q, frame_err_d;

    logic rise, fall1, fall2, full, have_eff, load;
    logic signed [15:0] word_dec;

    // Offset-binary mantissa minus 512 is just the MSB inverted.
    function automatic logic signed [15:0] decode(input logic [15:0] w);
        logic [2:0]         e;
        logic signed [15:0] m;
        e = w[15:13];
        m = {{6{~w[12]}}, ~w[12], w[11:3]};
        if (e == 3'd0)
            return 16'sd0;
        else
            return m <<< (e - 3'd1);
    endfunction

    assign rise     = phi1 & ~phi1_q;
    assign fall1    = sh1_q & ~SH1;
    assign fall2    = sh2_q & ~SH2;
    assign full     = (bitcnt_q == 5'd16);
    assign word_dec = decode(shreg_q);

    always_comb begin
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        have_left_d = have_left_q;
        left_hold_d = left_hold_q;
        left_d      = left_q;
        right_d     = right_q;
        out_valid_d = out_valid_q;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;
        have_eff    = have_left_q;
        load        = 1'b0;

        if (rise) begin
            shreg_d = {SO, shreg_q[15:1]};
            if (!full)
                bitcnt_d = bitcnt_q + 5'd1;
        end

        // Left word first, so a coincident SH2 fall sees the fresh left_hold.
        if (fall1) begin
            if (full) begin
                left_hold_d = word_dec;
                have_left_d = 1'b1;
                have_eff    = 1'b1;
            end else begin
                frame_err_d = 1'b1;
            end
        end

        if (fall2) begin
            if (full && have_eff) begin
                right_d     = word_dec;
                left_d      = left_hold_d;
                have_left_d = 1'b0;
                load        = 1'b1;
            end else begin
                frame_err_d = 1'b1;
            end
        end

        // A rise coinciding with a word end is the first bit of the next word.
        if (fall1 || fall2)
            bitcnt_d = rise ? 5'd1 : 5'd0;

        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;
        if (load) begin
            out_valid_d = 1'b1;
            overrun_d   = out_valid_q & ~out_ready;
        end
    end

    always_ff @(posedge phiM) begin
        if (reset) begin
            phi1_q      <= 1'b1;
            sh1_q       <= 1'b1;
            sh2_q       <= 1'b1;
            shreg_q     <= 16'd0;
            bitcnt_q    <= 5'd0;
            have_left_q <= 1'b0;
            left_hold_q <= 16'sd0;
            left_q      <= 16'sd0;
            right_q     <= 16'sd0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            phi1_q      <= phi1;
            sh1_q       <= SH1;
            sh2_q       <= SH2;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            have_left_q <= have_left_d;
            left_hold_q <= left_hold_d;
            left_q      <= left_d;
            right_q     <= right_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign left      = left_q;
    assign right     = right_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_y3012_deserializer.sv
// Directed bench for y3012_deserializer with hand-computed expected samples.
module tb_y3012_deserializer;

    logic        phiM = 1'b0;
    logic        reset, phi1, SO, SH1, SH2, out_ready;
    logic [15:0] left, right;
    logic        out_valid, overrun, frame_err;
    logic        ferr, ov;
    int          checks   = 0;
    int          failures = 0;

    y3012_deserializer dut (
        .phiM(phiM), .reset(reset), .phi1(phi1), .SO(SO), .SH1(SH1), .SH2(SH2),
        .left(left), .right(right), .out_valid(out_valid), .out_ready(out_ready),
        .overrun(overrun), .frame_err(frame_err)
    );

    always #5 phiM = ~phiM;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge phiM); SO = b; phi1 = 1'b1;
        @(negedge phiM); phi1 = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(w[i]);
    endtask

    task automatic sh_fall(input logic ch1, input logic ch2, output logic fe, output logic ovr);
        @(negedge phiM);
        if (ch1) SH1 = 1'b0;
        if (ch2) SH2 = 1'b0;
        @(negedge phiM);
        fe  = frame_err;
        ovr = overrun;
        SH1 = 1'b1;
        SH2 = 1'b1;
    endtask

    task automatic send_pair(input logic [15:0] wl, input logic [15:0] wr, output logic fe, output logic ovr);
        logic fe1, ov1;
        send_bits(wl, 16);
        sh_fall(1'b1, 1'b0, fe1, ov1);
        send_bits(wr, 16);
        sh_fall(1'b0, 1'b1, fe, ovr);
        fe = fe | fe1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge phiM);
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; phi1 = 1'b0; SO = 1'b0; SH1 = 1'b1; SH2 = 1'b1; out_ready = 1'b0;
        repeat (3) @(negedge phiM);
        check("rst_left", left, 16'h0000);
        check("rst_right", right, 16'h0000);
        check("rst_valid", {15'd0, out_valid}, 16'd1 - 16'd1);
        check("rst_flags", {14'd0, overrun, frame_err}, 16'h0000);
        reset = 1'b0;
        @(negedge phiM);

        // Basic pair
        send_pair(16'h7800, 16'hE800, ferr, ov);
        check("basic_valid", {15'd0, out_valid}, 16'd1);
        check("basic_left", left, 16'h0400);
        check("basic_right", right, 16'hC000);
        check("basic_flags", {14'd0, ov, ferr}, 16'h0000);

        // Extremes loaded over an unconsumed pair -> overrun
        send_pair(16'hFFFF, 16'hE000, ferr, ov);
        check("ovr_pulse", {15'd0, ov}, 16'd1);
        check("max_left", left, 16'h7FC0);
        check("min_right", right, 16'h8000);
        check("ovr_valid", {15'd0, out_valid}, 16'd1);
        @(negedge phiM);
        check("ovr_one_cycle", {15'd0, overrun}, 16'd0);
        consume();
        check("consumed", {15'd0, out_valid}, 16'd0);

        // E = 0 gives zero; dummy bits ignored
        send_pair(16'h0AA8, 16'h300F, ferr, ov);
        check("e0_left", left, 16'h0000);
        check("e1_right", right, 16'h0001);
        check("e0_ovr", {15'd0, ov}, 16'd0);

        // Load with out_ready high: old pair consumed, no overrun
        send_bits(16'h7800, 16);
        sh_fall(1'b1, 1'b0, ferr, ov);
        send_bits(16'hE800, 16);
        out_ready = 1'b1;
        sh_fall(1'b0, 1'b1, ferr, ov);
        check("rdy_ovr", {15'd0, ov}, 16'd0);
        check("rdy_valid", {15'd0, out_valid}, 16'd1);
        check("rdy_left", left, 16'h0400);
        @(negedge phiM);
        check("rdy_consumed", {15'd0, out_valid}, 16'd0);
        out_ready = 1'b0;

        // Short left word
        send_bits(16'hFFFF, 10);
        sh_fall(1'b1, 1'b0, ferr, ov);
        check("short_ferr", {15'd0, ferr}, 16'd1);
        @(negedge phiM);
        check("ferr_one_cycle", {15'd0, frame_err}, 16'd0);
        send_bits(16'hE800, 16);
        sh_fall(1'b0, 1'b1, ferr, ov);
        check("orphan_ferr", {15'd0, ferr}, 16'd1);
        check("orphan_valid", {15'd0, out_valid}, 16'd0);

        // Simultaneous SH1 and SH2 falls
        send_bits(16'hE000, 16);
        sh_fall(1'b1, 1'b1, ferr, ov);
        check("both_ferr", {15'd0, ferr}, 16'd0);
        check("both_valid", {15'd0, out_valid}, 16'd1);
        check("both_left", left, 16'h8000);
        check("both_right", right, 16'h8000);
        consume();

        // SH1 fall coinciding with the first rise of the right word
        send_bits(16'h7800, 16);
        @(negedge phiM); SH1 = 1'b0; SO = 1'b0; phi1 = 1'b1;
        @(negedge phiM); ferr = frame_err; phi1 = 1'b0; SH1 = 1'b1;
        check("coin_ferr", {15'd0, ferr}, 16'd0);
        for (int i = 1; i < 16; i++) send_bit(((16'hE800 >> i) & 16'h1) != 16'h0);
        sh_fall(1'b0, 1'b1, ferr, ov);
        check("coin_ferr2", {15'd0, ferr}, 16'd0);
        check("coin_left", left, 16'h0400);
        check("coin_right", right, 16'hC000);

        // Reset mid-word with a pair still held
        send_bits(16'h1234, 8);
        @(negedge phiM); reset = 1'b1;
        @(negedge phiM); reset = 1'b0;
        check("mid_rst_left", left, 16'h0000);
        check("mid_rst_right", right, 16'h0000);
        check("mid_rst_valid", {15'd0, out_valid}, 16'd0);
        send_pair(16'hE800, 16'h7800, ferr, ov);
        check("post_rst_ferr", {15'd0, ferr}, 16'd0);
        check("post_rst_left", left, 16'hC000);
        check("post_rst_right", right, 16'h0400);
        check("post_rst_valid", {15'd0, out_valid}, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
